ex_mem_skid: RTL and testbench
==============================

// Module: ex_mem_skid
// PURPOSE
//  Registered EX->MEM pipeline boundary with a 2-entry skid buffer.
//  - Captures execute-stage results (dest addr, write enable, data) and presents them to the memory stage.
//  - Valid/ready handshake on both sides; full throughput of one result per cycle.
//  - Absorbs one extra result when MEM stalls, so the EX ready path is registered (no combinational ready chain).
// PARAMETERS
//  DATA_W  32  result data width (`RegBus)
//  ADDR_W  5   register address width (`RegAddrBus)
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  rst            in   1       synchronous reset, active-high
//  flush          in   1       synchronous kill of all held results
//  ex_valid       in   1       EX presents a result this cycle
//  ex_ready       out  1       block can accept a result (registered)
//  ex_dest_addr   in   ADDR_W  destination register address
//  ex_wreg        in   1       write-back enable
//  ex_dest_data   in   DATA_W  result data
//  mem_valid      out  1       output entry valid
//  mem_ready      in   1       MEM consumes the output entry
//  mem_dest_addr  out  ADDR_W  output destination address
//  mem_wreg       out  1       output write-back enable
//  mem_dest_data  out  DATA_W  output result data
// BEHAVIOUR
//  Storage and handshake
//  - Two entries: OUT (drives mem_*) and SKID.
//  - Transfer in: ex_valid && ex_ready. Transfer out: mem_valid && mem_ready.
//  States, encoded by occupancy:
//  - EMPTY: OUT and SKID both invalid.
//  - ONE: OUT valid, SKID invalid.
//  - TWO: OUT and SKID both valid.
//  Transitions:
//  - EMPTY: in -> ONE (load OUT).
//  - ONE: in, no out -> TWO (load SKID). Out, no in -> EMPTY. In and out -> ONE (reload OUT).
//  - TWO: out -> ONE (SKID moves to OUT). No in is possible because ex_ready=0.
//  Ready
//  - ex_ready is a register equal to !(next state == TWO).
//  - ex_ready=0 exactly while in TWO.
//  Latency and ordering
//  - 1 cycle from an accepted input to mem_valid in EMPTY.
//  - Strict FIFO order.
//  - mem_* are stable while mem_valid && !mem_ready.
//  - Entries with ex_wreg=0 are carried unchanged, not dropped.
//  Priority
//  - rst > flush > handshakes.
//  - flush: next state EMPTY, ex_ready=1, any same-cycle input is discarded.
//  Reset values (also applied by flush)
//  - mem_valid=0, mem_dest_addr=0, mem_wreg=0, mem_dest_data=0.
//  - ex_ready=1; SKID cleared.
//  - Reset mid-stall discards both entries.
//  Invalid-output rule: when mem_valid=0, mem_wreg is forced 0.
//  Simultaneous in/out in ONE must not bubble, so back-to-back throughput is maintained.
// CONFIGURATION
//  Macro EX_MEM_FWD_EN.
//  - Defined: adds outputs fwd_we (1), fwd_addr (ADDR_W), fwd_data (DATA_W).
//    - These equal mem_wreg && mem_valid, mem_dest_addr, mem_dest_data.
//    - Combinational from the OUT entry; 0 on reset/flush.
//    - Used by decode to forward operands.
//  - Undefined: the ports and their logic are absent.
// TESTING
//  1. Reset then ex_valid=1, addr=5, wreg=1, data=32'hDEADBEEF, mem_ready=1 -> next cycle mem_valid=1 with that data; ex_ready stays 1.
//  2. mem_ready=0, push A=32'h1 then B=32'h2 -> ex_ready=0 after B. Raise mem_ready -> A then B in consecutive cycles, ex_ready=1 again.
//  3. mem_ready=1, push 32'h10..32'h17 on consecutive cycles -> 8 outputs on 8 consecutive cycles, in order, no bubbles.
//  4. State TWO with flush=1 and ex_valid=1 (data 32'h99) -> next cycle mem_valid=0, ex_ready=1; 32'h99 never appears.
//  5. rst=1 while TWO -> all outputs at reset values next cycle. With EX_MEM_FWD_EN: push addr=3, data=7 -> fwd_we=1, fwd_addr=3, fwd_data=7 while held.

Source files
------------

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline boundary with a 2-entry skid buffer (OUT + SKID) and a registered ex_ready.
// Optional forwarding outputs are enabled by defining EX_MEM_FWD_EN.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_dest_addr,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_dest_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_dest_addr,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_dest_data
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_we,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t            state_p1, state_nxt;
  logic              ready_p1;
  logic [ADDR_W-1:0] out_addr_p1, skid_addr_p2;
  logic              out_wreg_p1, skid_wreg_p2;
  logic [DATA_W-1:0] out_data_p1, skid_data_p2;
  logic              in_xfer, out_xfer;
  logic              ld_out, ld_skid, shift;

  always_comb begin
    state_nxt = state_p1;
    ld_out    = 1'b0;
    ld_skid   = 1'b0;
    shift     = 1'b0;
    in_xfer   = ex_valid && ready_p1;
    out_xfer  = (state_p1 != S_EMPTY) && mem_ready;
    case (state_p1)
      S_EMPTY: begin
        if (in_xfer) begin
          state_nxt = S_ONE;
          ld_out    = 1'b1;
        end
      end
      S_ONE: begin
        // Simultaneous in/out reloads OUT directly so streaming never bubbles.
        if (in_xfer && out_xfer) begin
          ld_out = 1'b1;
        end else if (in_xfer) begin
          state_nxt = S_TWO;
          ld_skid   = 1'b1;
        end else if (out_xfer) begin
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          state_nxt = S_ONE;
          shift     = 1'b1;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Stage boundary: OUT (p1) and SKID (p2) registers
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_p1     <= S_EMPTY;
      ready_p1     <= 1'b1;
      out_addr_p1  <= '0;
      out_wreg_p1  <= 1'b0;
      out_data_p1  <= '0;
      skid_addr_p2 <= '0;
      skid_wreg_p2 <= 1'b0;
      skid_data_p2 <= '0;
    end else begin
      state_p1 <= state_nxt;
      ready_p1 <= (state_nxt != S_TWO);
      if (ld_out) begin
        out_addr_p1 <= ex_dest_addr;
        out_wreg_p1 <= ex_wreg;
        out_data_p1 <= ex_dest_data;
      end else if (shift) begin
        out_addr_p1 <= skid_addr_p2;
        out_wreg_p1 <= skid_wreg_p2;
        out_data_p1 <= skid_data_p2;
      end
      if (ld_skid) begin
        skid_addr_p2 <= ex_dest_addr;
        skid_wreg_p2 <= ex_wreg;
        skid_data_p2 <= ex_dest_data;
      end else if (shift) begin
        skid_addr_p2 <= '0;
        skid_wreg_p2 <= 1'b0;
        skid_data_p2 <= '0;
      end
    end
  end

  assign ex_ready      = ready_p1;
  assign mem_valid     = (state_p1 != S_EMPTY);
  assign mem_dest_addr = out_addr_p1;
  assign mem_wreg      = out_wreg_p1 && mem_valid;
  assign mem_dest_data = out_data_p1;

`ifdef EX_MEM_FWD_EN
  assign fwd_we   = out_wreg_p1 && mem_valid;
  assign fwd_addr = out_addr_p1;
  assign fwd_data = out_data_p1;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: directed scenarios plus random traffic against a
// queue-based model of a 2-deep in-order buffer.
module tb_ex_mem_skid;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, flush, ex_valid, ex_ready, ex_wreg;
  logic [ADDR_W-1:0] ex_dest_addr;
  logic [DATA_W-1:0] ex_dest_data;
  logic              mem_valid, mem_ready, mem_wreg;
  logic [ADDR_W-1:0] mem_dest_addr;
  logic [DATA_W-1:0] mem_dest_data;
`ifdef EX_MEM_FWD_EN
  logic              fwd_we;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  ex_mem_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_dest_addr(ex_dest_addr), .ex_wreg(ex_wreg), .ex_dest_data(ex_dest_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_dest_addr(mem_dest_addr), .mem_wreg(mem_wreg), .mem_dest_data(mem_dest_data)
`ifdef EX_MEM_FWD_EN
    , .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wreg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t q[$];
  logic   model_ready;
  int     n_chk  = 0;
  int     n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ex_ready", 64'(ex_ready), 64'(model_ready));
    chk("mem_valid", 64'(mem_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("mem_addr", 64'(mem_dest_addr), 64'(q[0].addr));
      chk("mem_wreg", 64'(mem_wreg), 64'(q[0].wreg));
      chk("mem_data", 64'(mem_dest_data), 64'(q[0].data));
    end else begin
      chk("mem_wreg_idle", 64'(mem_wreg), 64'd0);
    end
`ifdef EX_MEM_FWD_EN
    chk("fwd_we", 64'(fwd_we), 64'((q.size() > 0) && q[0].wreg));
    chk("fwd_addr", 64'(fwd_addr), 64'(mem_dest_addr));
    chk("fwd_data", 64'(fwd_data), 64'(mem_dest_data));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic w,
                      input logic [DATA_W-1:0] d, input logic mr, input logic fl);
    entry_t e;
    logic   in_x, out_x;
    ex_valid = v; ex_dest_addr = a; ex_wreg = w; ex_dest_data = d;
    mem_ready = mr; flush = fl;
    in_x  = v && model_ready;
    out_x = (q.size() > 0) && mr;
    e.addr = a; e.wreg = w; e.data = d;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(e);
    end
    model_ready = (q.size() < 2);
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_ready"}, 64'(ex_ready), 64'd1);
    chk({tag, "_addr"}, 64'(mem_dest_addr), 64'd0);
    chk({tag, "_wreg"}, 64'(mem_wreg), 64'd0);
    chk({tag, "_data"}, 64'(mem_dest_data), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    model_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_wreg = 1'b0;
    ex_dest_addr = '0; ex_dest_data = '0; mem_ready = 1'b0;
    model_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: single transfer, 1-cycle latency
    step(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("t1_data", 64'(mem_dest_data), 64'hDEADBEEF);
    step(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);

    // 2: stall, fill both entries, then drain in order
    step(1'b1, 5'd1, 1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 5'd2, 1'b0, 32'h2, 1'b0, 1'b0);
    chk("t2_full_ready", 64'(ex_ready), 64'd0);
    step(1'b1, 5'd9, 1'b1, 32'h55, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_second", 64'(mem_dest_data), 64'h2);
    step(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_ready_back", 64'(ex_ready), 64'd1);

    // 3: back-to-back streaming, no bubbles
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'(i), 1'(i % 2), 32'h10 + 32'(i), 1'b1, 1'b0);
      chk("t3_stream", 64'(mem_dest_data), 64'(32'h10 + 32'(i)));
    end
    step(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);

    // 4: flush while full discards everything, including same-cycle input
    step(1'b1, 5'd3, 1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 5'd4, 1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 5'd6, 1'b1, 32'h99, 1'b0, 1'b1);
    check_reset_vals("flush");
    step(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_no99", 64'(mem_valid), 64'd0);

    // 5: reset while full
    step(1'b1, 5'd7, 1'b1, 32'hC, 1'b0, 1'b0);
    step(1'b1, 5'd8, 1'b1, 32'hD, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 5'd3, 1'b1, 32'h7, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef EX_MEM_FWD_EN
    chk("t5_fwd_we", 64'(fwd_we), 64'd1);
    chk("t5_fwd_addr", 64'(fwd_addr), 64'd3);
    chk("t5_fwd_data", 64'(fwd_data), 64'd7);
`endif
    step(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom),
           32'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
